// File: rtl/mc_wb_master.sv
// WISHBONE classic initiator: turns a request/beat-data handshake into single or
// incrementing-burst cyc/stb cycles, with wait-state insertion, err abort and beat timeout.
module mc_wb_master #(
    parameter int TO_W    = 8,
    parameter int TIMEOUT = 200
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [3:0]  req_sel,
    input  logic [3:0]  req_len,
    input  logic        beat_hold,
    input  logic [31:0] wr_data,
    output logic        wr_data_ack,
    output logic [31:0] rd_data,
    output logic        rd_valid,
    output logic        done,
    output logic        done_err,
    output logic [31:0] wb_addr_o,
    output logic [31:0] wb_data_o,
    input  logic [31:0] wb_data_i,
    output logic [3:0]  wb_sel_o,
    output logic        wb_we_o,
    output logic        wb_cyc_o,
    output logic        wb_stb_o,
    input  logic        wb_ack_i,
    input  logic        wb_err_i
);

    typedef enum logic [1:0] {S_IDLE, S_BEAT, S_GAP, S_END} state_t;

    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

    state_t          state, state_nxt;
    logic [3:0]      beats_left, beats_left_nxt;
    logic [TO_W-1:0] to_cnt, to_cnt_nxt;
    logic [31:0]     addr_nxt, data_nxt, rd_data_nxt;
    logic [3:0]      sel_nxt;
    logic            we_nxt, cyc_nxt, stb_nxt;
    logic            rd_valid_nxt, wr_ack_nxt, done_nxt, done_err_nxt, req_ready_nxt;
    logic            timeout_hit;

    // The counter value TIMEOUT-1 means this is the TIMEOUT-th strobe cycle without a response.
    assign timeout_hit = (TIMEOUT != 0) && (to_cnt == TO_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            beats_left  <= '0;
            to_cnt      <= '0;
            wb_addr_o   <= '0;
            wb_data_o   <= '0;
            wb_sel_o    <= '0;
            wb_we_o     <= 1'b0;
            wb_cyc_o    <= 1'b0;
            wb_stb_o    <= 1'b0;
            rd_data     <= '0;
            rd_valid    <= 1'b0;
            wr_data_ack <= 1'b0;
            done        <= 1'b0;
            done_err    <= 1'b0;
            req_ready   <= 1'b1;
        end else begin
            state       <= state_nxt;
            beats_left  <= beats_left_nxt;
            to_cnt      <= to_cnt_nxt;
            wb_addr_o   <= addr_nxt;
            wb_data_o   <= data_nxt;
            wb_sel_o    <= sel_nxt;
            wb_we_o     <= we_nxt;
            wb_cyc_o    <= cyc_nxt;
            wb_stb_o    <= stb_nxt;
            rd_data     <= rd_data_nxt;
            rd_valid    <= rd_valid_nxt;
            wr_data_ack <= wr_ack_nxt;
            done        <= done_nxt;
            done_err    <= done_err_nxt;
            req_ready   <= req_ready_nxt;
        end
    end

    // Every output is registered, so this block computes the next value of each register.
    always_comb begin
        state_nxt      = state;
        beats_left_nxt = beats_left;
        to_cnt_nxt     = '0;
        addr_nxt       = wb_addr_o;
        data_nxt       = wb_data_o;
        sel_nxt        = wb_sel_o;
        we_nxt         = wb_we_o;
        cyc_nxt        = wb_cyc_o;
        stb_nxt        = wb_stb_o;
        rd_data_nxt    = rd_data;
        rd_valid_nxt   = 1'b0;
        wr_ack_nxt     = 1'b0;
        done_nxt       = 1'b0;
        done_err_nxt   = 1'b0;
        req_ready_nxt  = req_ready;

        case (state)
            S_IDLE: begin
                if (req_valid && req_ready) begin
                    state_nxt      = S_BEAT;
                    req_ready_nxt  = 1'b0;
                    cyc_nxt        = 1'b1;
                    stb_nxt        = 1'b1;
                    we_nxt         = req_we;
                    addr_nxt       = req_addr;
                    sel_nxt        = req_sel;
                    beats_left_nxt = req_len;
                    if (req_we) begin
                        data_nxt   = wr_data;
                        wr_ack_nxt = 1'b1;
                    end
                end
            end

            S_BEAT: begin
                // err outranks ack; an ack arriving on the timeout cycle still completes the beat.
                if (wb_err_i || (timeout_hit && !wb_ack_i)) begin
                    state_nxt    = S_END;
                    cyc_nxt      = 1'b0;
                    stb_nxt      = 1'b0;
                    we_nxt       = 1'b0;
                    done_nxt     = 1'b1;
                    done_err_nxt = 1'b1;
                end else if (wb_ack_i) begin
                    if (!wb_we_o) begin
                        rd_data_nxt  = wb_data_i;
                        rd_valid_nxt = 1'b1;
                    end
                    if (beats_left == 4'd0) begin
                        state_nxt = S_END;
                        cyc_nxt   = 1'b0;
                        stb_nxt   = 1'b0;
                        we_nxt    = 1'b0;
                        done_nxt  = 1'b1;
                    end else begin
                        beats_left_nxt = beats_left - 4'd1;
                        addr_nxt       = wb_addr_o + 32'd4;
                        if (wb_we_o) begin
                            data_nxt   = wr_data;
                            wr_ack_nxt = 1'b1;
                        end
                        if (beat_hold) begin
                            stb_nxt   = 1'b0;
                            state_nxt = S_GAP;
                        end
                    end
                end else begin
                    to_cnt_nxt = to_cnt + 1'b1;
                end
            end

            S_GAP: begin
                if (!beat_hold) begin
                    stb_nxt   = 1'b1;
                    state_nxt = S_BEAT;
                end
            end

            S_END: begin
                state_nxt     = S_IDLE;
                req_ready_nxt = 1'b1;
            end

            default: state_nxt = S_IDLE;
        endcase
    end

endmodule
